// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI TX frame controller.
package spi_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam int          WORD_LEN_MIN    = 8;
    localparam int          WORD_LEN_MAX    = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_REFILL,
        ST_CRC,
        ST_DRAIN
    } state_t;

    // Reflected CRC-32 over the low len bits of data, LSB first.
    function automatic logic [31:0] crc32_update(input logic [31:0] crc,
                                                 input logic [31:0] data,
                                                 input logic [4:0]  len);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(len)) begin
                if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
                else                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Configured word length forced into the range the shifter supports.
    function automatic logic [4:0] clamp_len(input logic [5:0] l);
        if (l < 6'(WORD_LEN_MIN))      return 5'(WORD_LEN_MIN);
        else if (l > 6'(WORD_LEN_MAX)) return 5'(WORD_LEN_MAX);
        else                           return l[4:0];
    endfunction

endpackage

// File: rtl/spi_crc32_word.sv
// Combinational one-word CRC-32 step: folds the low len bits of data into crc_in.
module spi_crc32_word (
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    input  logic [4:0]  len,
    output logic [31:0] crc_next
);
    import spi_pkg::*;

    assign crc_next = crc32_update(crc_in, data, len);

endmodule

// File: rtl/spi_tx_frame_ctrl.sv
// Feeds words from a valid/ready source to the SPI TX shifter, counts words
// per frame, appends a CRC-32 word and reports frame completion.
module spi_tx_frame_ctrl #(
    parameter int          WCNT_W     = 8,
    parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WCNT_W-1:0] cfg_frame_words,
    input  logic [5:0]        cfg_word_len,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              txe,
    output logic [31:0]       tx_data,
    output logic [4:0]        data_len,
    output logic              crc_sel,
    output logic [31:0]       crc_out,
    input  logic              txe_flag,
    input  logic              tx_done,
    output logic              busy,
    output logic              frame_done,
    output logic              err_underrun
);
    import spi_pkg::*;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] frame_words;
    logic [31:0]       crc_reg;
    logic [31:0]       crc_seed;
    logic [31:0]       crc_next;
    logic [4:0]        len_sel;
    logic              pres, pres_d1, pres_d2;
    logic              acc;
    logic              last_word;

    // Something is offered to the shifter whenever a data word or the CRC is up.
    assign pres      = ~txe | crc_sel;
    // A txe_flag only counts if a word was offered at the load point two cycles back.
    assign acc       = txe_flag & pres_d2;
    assign last_word = (wcnt == frame_words - WCNT_W'(1));

    // At frame start the CRC seeds from CRC_INIT with the freshly clamped length.
    assign crc_seed  = (state == ST_IDLE) ? CRC_INIT : crc_reg;
    assign len_sel   = (state == ST_IDLE) ? clamp_len(cfg_word_len) : data_len;
    assign crc_out   = crc_reg ^ CRC_XOROUT;

    spi_crc32_word u_crc (
        .crc_in   (crc_seed),
        .data     (s_data),
        .len      (len_sel),
        .crc_next (crc_next)
    );

    // Two-stage delay of the presentation flag to line up with txe_flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres_d1 <= 1'b0;
            pres_d2 <= 1'b0;
        end else begin
            pres_d1 <= pres;
            pres_d2 <= pres_d1;
        end
    end

    // Frame FSM with registered outputs; abort overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            txe          <= 1'b1;
            tx_data      <= '0;
            data_len     <= 5'(WORD_LEN_MIN);
            crc_sel      <= 1'b0;
            crc_reg      <= CRC_INIT;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            err_underrun <= 1'b0;
            wcnt         <= '0;
            frame_words  <= WCNT_W'(1);
        end else begin
            s_ready      <= 1'b0;
            frame_done   <= 1'b0;
            err_underrun <= 1'b0;
            if (abort) begin
                state   <= ST_IDLE;
                txe     <= 1'b1;
                crc_sel <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (s_valid) begin
                            frame_words <= (cfg_frame_words == '0) ? WCNT_W'(1) : cfg_frame_words;
                            data_len    <= len_sel;
                            tx_data     <= s_data;
                            s_ready     <= 1'b1;
                            crc_reg     <= crc_next;
                            wcnt        <= '0;
                            txe         <= 1'b0;
                            busy        <= 1'b1;
                            state       <= ST_PRESENT;
                        end
                    end
                    ST_PRESENT: begin
                        if (acc) begin
                            if (last_word) begin
                                crc_sel <= 1'b1;
                                txe     <= 1'b1;
                                state   <= ST_CRC;
                            end else begin
                                wcnt <= wcnt + WCNT_W'(1);
                                if (s_valid) begin
                                    tx_data <= s_data;
                                    s_ready <= 1'b1;
                                    crc_reg <= crc_next;
                                end else begin
                                    err_underrun <= 1'b1;
                                    txe          <= 1'b1;
                                    state        <= ST_REFILL;
                                end
                            end
                        end
                    end
                    ST_REFILL: begin
                        if (s_valid) begin
                            tx_data <= s_data;
                            s_ready <= 1'b1;
                            crc_reg <= crc_next;
                            txe     <= 1'b0;
                            state   <= ST_PRESENT;
                        end
                    end
                    ST_CRC: begin
                        if (acc) begin
                            crc_sel <= 1'b0;
                            state   <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        // First tx_done after the CRC load is the CRC word's last bit.
                        if (tx_done) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_frame_ctrl.sv
// Directed bench for spi_tx_frame_ctrl with a free-running shifter/source model.
module tb_spi_tx_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_frame_words;
    logic [5:0]  cfg_word_len;
    logic        abort;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready, txe, crc_sel, busy, frame_done, err_underrun;
    logic [31:0] tx_data, crc_out;
    logic [4:0]  data_len;
    logic        txe_flag, tx_done;

    logic        use_model, man_flag, man_done;
    logic        m_flag, m_done;
    logic [31:0] src_q[$];
    bit          dq[$];
    int          rd_ptr, slot_cnt, slot_len, crc_len_seen;
    logic [31:0] crc_seen;
    int          n_sready, n_under, n_fd, n_fd_ok;
    int          n_chk, n_pass;

    always #5 clk = ~clk;

    assign txe_flag = use_model ? m_flag : man_flag;
    assign tx_done  = use_model ? m_done : man_done;

    spi_tx_frame_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_frame_words(cfg_frame_words),
        .cfg_word_len(cfg_word_len), .abort(abort), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .txe(txe), .tx_data(tx_data),
        .data_len(data_len), .crc_sel(crc_sel), .crc_out(crc_out),
        .txe_flag(txe_flag), .tx_done(tx_done), .busy(busy),
        .frame_done(frame_done), .err_underrun(err_underrun)
    );

    // Shifter and source model on the falling edge: slots of data_len cycles,
    // load at count 0, txe_flag at 2, tx_done on the last bit.
    always @(negedge clk) begin
        if (!rst_n) begin
            slot_cnt = 0; slot_len = 8; m_flag = 1'b0; m_done = 1'b0;
            rd_ptr = src_q.size(); s_valid = 1'b0; s_data = 32'h0;
        end else begin
            if (s_ready) begin n_sready++; rd_ptr++; end
            if (err_underrun) n_under++;
            if (frame_done) begin n_fd++; if (m_done) n_fd_ok++; end
            s_valid = (rd_ptr < src_q.size());
            s_data  = s_valid ? src_q[rd_ptr] : 32'h0;
            if (slot_cnt == 0) begin
                slot_len = int'(data_len);
                if (use_model && crc_sel) begin
                    crc_seen = crc_out; crc_len_seen = slot_len;
                end else if (use_model && !txe) begin
                    for (int i = 0; i < slot_len; i++) dq.push_back(tx_data[i]);
                end
            end
            m_flag   = (slot_cnt == 2);
            m_done   = (slot_cnt == slot_len - 1);
            slot_cnt = m_done ? 0 : slot_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_fd(input string tag, input int lim);
        int k = 0;
        while (frame_done !== 1'b1 && k < lim) begin tick(); k++; end
        chk(tag, frame_done, 1);
    endtask

    task automatic wait_crc(input string tag, input int lim);
        int k = 0;
        while (crc_sel !== 1'b1 && k < lim) begin tick(); k++; end
        chk(tag, crc_sel, 1);
    endtask

    task automatic wait_busy(input string tag, input int lim);
        int k = 0;
        while (busy !== 1'b1 && k < lim) begin tick(); k++; end
        chk(tag, busy, 1);
    endtask

    task automatic wait_under(input string tag, input int lim);
        int k = 0;
        while (err_underrun !== 1'b1 && k < lim) begin tick(); k++; end
        chk(tag, err_underrun, 1);
    endtask

    task automatic push_digits();
        for (int b = 0; b < 9; b++) src_q.push_back(32'(32'h31 + b));
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_txe"}, txe, 1);            chk({p, "_tx_data"}, tx_data, 0);
        chk({p, "_data_len"}, data_len, 8);  chk({p, "_crc_sel"}, crc_sel, 0);
        chk({p, "_crc_out"}, crc_out, 0);    chk({p, "_s_ready"}, s_ready, 0);
        chk({p, "_busy"}, busy, 0);          chk({p, "_frame_done"}, frame_done, 0);
        chk({p, "_underrun"}, err_underrun, 0);
    endtask

    // Independent bit-serial CRC-32 over a captured bit stream.
    function automatic logic [31:0] ref_crc(input bit q[$], input int from);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = from; i < q.size(); i++)
            c = (c >> 1) ^ ((c[0] ^ q[i]) ? 32'hEDB88320 : 32'h0);
        return c ^ 32'hFFFFFFFF;
    endfunction

    function automatic logic [31:0] dq_word(input int base, input int n);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < n; i++) if (base + i < dq.size()) w[i] = dq[base + i];
        return w;
    endfunction

    initial begin
        int s0, u0, f0, fo0, d0;
        logic [31:0] w;
        bit lq[$];
        use_model = 1'b1; man_flag = 1'b0; man_done = 1'b0; abort = 1'b0;
        cfg_frame_words = 8'd9; cfg_word_len = 6'd8; rst_n = 1'b0;
        tick(); tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_busy", busy, 0);

        // 9-word "123456789" frame, golden CRC-32
        s0 = n_sready; f0 = n_fd; fo0 = n_fd_ok; d0 = dq.size();
        push_digits();
        wait_crc("t1_crc_state", 600);
        chk("t1_crc_golden", crc_out, 32'hCBF43926);
        wait_fd("t1_frame_done", 200);
        tick();
        chk("t1_fd_pulse", frame_done, 0);
        chk("t1_fd_after_txdone", n_fd_ok - fo0, 1);
        chk("t1_sready_cnt", n_sready - s0, 9);
        chk("t1_bits", dq.size() - d0, 72);
        for (int b = 0; b < 9; b++)
            chk($sformatf("t1_byte%0d", b), dq_word(d0 + 8 * b, 8), 32'(32'h31 + b));
        chk("t1_crc_len", crc_len_seen, 8);
        chk("t1_crc_byte", crc_seen & 32'hFF, 32'h26);
        chk("t1_idle", busy, 0);

        // Underrun between word 1 and word 2, len 20
        cfg_frame_words = 8'd2; cfg_word_len = 6'd20;
        u0 = n_under; d0 = dq.size();
        src_q.push_back(32'hFFFABCDE);
        wait_under("t2_underrun", 300);
        chk("t2_refill_txe", txe, 1);
        chk("t2_refill_busy", busy, 1);
        chk("t2_data_len", data_len, 20);
        tick();
        chk("t2_underrun_pulse", err_underrun, 0);
        src_q.push_back(32'h00013579);
        wait_fd("t2_frame_done", 300);
        tick();
        chk("t2_underrun_cnt", n_under - u0, 1);
        chk("t2_bits", dq.size() - d0, 40);
        chk("t2_word1", dq_word(d0, 20), 32'hABCDE);
        chk("t2_word2", dq_word(d0 + 20, 20), 32'h13579);
        chk("t2_crc", crc_seen, ref_crc(dq, d0));
        chk("t2_crc_len", crc_len_seen, 20);

        // Manual flags: early txe_flag pulses must be ignored
        use_model = 1'b0; cfg_frame_words = 8'd2; cfg_word_len = 6'd8;
        s0 = n_sready; u0 = n_under;
        tick(); tick();
        src_q.push_back(32'h000000A5);
        @(negedge clk); #1;
        man_flag = 1'b1;
        tick();
        chk("t3_start", busy, 1);
        tick();
        man_flag = 1'b0;
        tick(); tick();
        chk("t3_txe_low", txe, 0);
        chk("t3_sready_once", n_sready - s0, 1);
        chk("t3_no_under", n_under - u0, 0);
        src_q.push_back(32'h0000005A);
        tick(); tick();
        man_flag = 1'b1; tick(); man_flag = 1'b0;
        chk("t3_accept_sready", s_ready, 1);
        chk("t3_accept_txe", txe, 0);
        chk("t3_accept_not_crc", crc_sel, 0);
        tick();
        man_flag = 1'b1; tick(); man_flag = 1'b0;
        chk("t3_crc_sel", crc_sel, 1);
        chk("t3_crc_txe", txe, 1);
        w = 32'hA5; for (int i = 0; i < 8; i++) lq.push_back(w[i]);
        w = 32'h5A; for (int i = 0; i < 8; i++) lq.push_back(w[i]);
        chk("t3_crc_val", crc_out, ref_crc(lq, 0));
        tick();
        man_flag = 1'b1; tick(); man_flag = 1'b0;
        chk("t3_drain_crc_sel", crc_sel, 0);
        chk("t3_drain_busy", busy, 1);
        chk("t3_drain_no_fd", frame_done, 0);
        man_done = 1'b1; tick(); man_done = 1'b0;
        chk("t3_fd", frame_done, 1);
        tick();
        chk("t3_fd_pulse", frame_done, 0);
        chk("t3_idle", busy, 0);
        use_model = 1'b1;

        // Length clamp high (40 -> 31), frame_words 0 treated as 1
        cfg_frame_words = 8'd0; cfg_word_len = 6'd40;
        s0 = n_sready; d0 = dq.size();
        src_q.push_back(32'hDEADBEEF);
        wait_busy("t4a_busy", 50);
        chk("t4a_data_len", data_len, 31);
        wait_fd("t4a_frame_done", 300);
        tick();
        chk("t4a_sready_cnt", n_sready - s0, 1);
        chk("t4a_bits", dq.size() - d0, 31);
        chk("t4a_word", dq_word(d0, 31), 32'h5EADBEEF);
        chk("t4a_crc", crc_seen, ref_crc(dq, d0));
        chk("t4a_crc_len", crc_len_seen, 31);

        // Length clamp low (3 -> 8); a mid-frame config change is ignored
        cfg_word_len = 6'd3; d0 = dq.size();
        src_q.push_back(32'h000001C5);
        wait_busy("t4b_busy", 50);
        chk("t4b_data_len", data_len, 8);
        cfg_word_len = 6'd20;
        wait_fd("t4b_frame_done", 300);
        tick();
        chk("t4b_len_held", data_len, 8);
        chk("t4b_bits", dq.size() - d0, 8);
        chk("t4b_word", dq_word(d0, 8), 32'hC5);
        chk("t4b_crc", crc_seen, ref_crc(dq, d0));

        // Abort while the CRC word is up, then a clean frame
        cfg_frame_words = 8'd9; cfg_word_len = 6'd8; f0 = n_fd;
        push_digits();
        wait_crc("t5_crc_state", 600);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_abort_crc_sel", crc_sel, 0);
        chk("t5_abort_txe", txe, 1);
        chk("t5_abort_busy", busy, 0);
        repeat (30) tick();
        chk("t5_no_fd", n_fd - f0, 0);
        push_digits();
        wait_crc("t5_crc_state2", 600);
        chk("t5_crc_golden", crc_out, 32'hCBF43926);
        wait_fd("t5_frame_done", 200);
        tick();

        // Asynchronous reset in the middle of PRESENT
        push_digits();
        wait_busy("t6_busy", 50);
        tick(); tick();
        chk("t6_present", txe, 0);
        rst_n = 1'b0; #1;
        chk_reset("arst");
        tick(); tick();
        rst_n = 1'b1; s0 = n_sready;
        repeat (10) tick();
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_txe", txe, 1);
        chk("t6_no_sready", n_sready - s0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_tx_frame_ctrl.md
Name: spi_tx_frame_ctrl

Overview:
- Upstream feeder for the SPI TX bit shifter. Pulls data words from a valid/ready word source and presents them to the shifter on its active-low txe/data interface.
- Counts words per frame and computes CRC-32 over the transmitted bits. After the last data word it asserts crc_sel so the shifter loads the CRC word.
- Pulses frame_done when the CRC word's last bit has left the shifter.

Parameters:
- WCNT_W, 8, width of frame word counter; frame length 1..2^WCNT_W-1 words.
- CRC_INIT, 32'hFFFFFFFF, CRC register seed at frame start.
- CRC_XOROUT, 32'hFFFFFFFF, final XOR applied to crc_out.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_frame_words  in  WCNT_W  data words per frame, sampled at frame start; 0 is treated as 1
- cfg_word_len  in  6  bits per word, sampled at frame start; clamped to 8..31
- abort  in  1  synchronous frame abort
- s_valid  in  1  source word available
- s_data  in  32  source word, LSB transmitted first
- s_ready  out  1  one-cycle pop strobe to the source
- txe  out  1  active-low "word presented" to the shifter
- tx_data  out  32  presented word (holding register)
- data_len  out  5  word length to the shifter
- crc_sel  out  1  shifter loads crc_out instead of tx_data
- crc_out  out  32  finalised CRC word
- txe_flag  in  1  shifter pulse, 2 cycles after each word-slot load point (free-running)
- tx_done  in  1  shifter pulse on the last bit of each word slot (free-running)
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at frame completion
- err_underrun  out  1  one-cycle pulse when the source was empty at a word boundary

Behaviour:
- Reset values: txe=1, tx_data=0, data_len=8, crc_sel=0, crc_out=CRC_XOROUT^CRC_INIT, s_ready=0, busy=0, frame_done=0, err_underrun=0. State=IDLE, word counter=0.
- Qualified acceptance: keep a 2-deep delay line of pres = (~txe | crc_sel).
  - acc = txe_flag & pres_d2.
  - Unqualified txe_flag and tx_done pulses are ignored.
- CRC: reflected polynomial 0xEDB88320, LSB-first. On each word capture, update with the low len bits of s_data (bit loop, masked by latched len).
  - crc_out = crc_reg ^ CRC_XOROUT, combinational from crc_reg.
- FSM states: IDLE, PRESENT, REFILL, CRC, DRAIN.
- IDLE:
  - txe=1, busy=0.
  - On s_valid: latch frame_words and clamped len (data_len drives len), capture s_data into tx_data, pulse s_ready, crc_reg=update(CRC_INIT, s_data), wcnt=0, go to PRESENT.
- PRESENT:
  - txe=0, busy=1.
  - On acc with wcnt==frame_words-1: go to CRC.
  - On acc otherwise: wcnt+1. If s_valid in the same cycle, capture the word and pulse s_ready, then stay in PRESENT (txe stays 0). Else pulse err_underrun and go to REFILL.
- REFILL:
  - txe=1.
  - On s_valid: capture the word, pulse s_ready, update crc, go to PRESENT.
- CRC:
  - crc_sel=1, txe=1.
  - On acc: crc_sel=0, go to DRAIN.
- DRAIN:
  - txe=1.
  - On the first tx_done: pulse frame_done, go to IDLE.
- The CRC word is transmitted with the frame's data_len. Only its low data_len bits go out; receivers compare the same truncation.
- abort, when sampled high in any state, returns to IDLE in the next cycle with txe=1 and crc_sel=0. No frame_done; abort has priority over acc.
- Simultaneous IDLE start and txe_flag: the flag is ignored because pres_d2=0.
- Config changes mid-frame have no effect until the next IDLE start.
- Asynchronous reset mid-frame returns all outputs to their reset values immediately.

Decomposition:
- Shared package spi_pkg holds:
  - CRC32_POLY_REFL=32'hEDB88320
  - WORD_LEN_MIN=8, WORD_LEN_MAX=31
  - FSM state enum for ST_IDLE..ST_DRAIN
  - function crc32_update(crc, data, len)
- Sub-module: spi_crc32_word, a combinational masked 32-bit LSB-first CRC update. The controller instantiates it once.

Test Plan:
- frame_words=9, len=8, words 0x31..0x39, shifter model connected -> 9 s_ready pulses; crc_out=0xCBF43926 during CRC; frame_done one cycle after the CRC word's tx_done; serial stream = bytes LSB-first, then 0x26.
- frame_words=2, len=20, s_valid dropped after word 1 -> err_underrun pulses once, txe=1 in REFILL; on s_valid, word 2 is presented and the frame completes normally.
- txe_flag pulsed in IDLE and in the first cycle of PRESENT (pres_d2=0) -> wcnt unchanged, no s_ready, stays in PRESENT.
- cfg_word_len=40, then 3 -> data_len=31, then 8; the CRC covers 31 or 8 bits respectively.
- abort asserted in CRC state -> next cycle IDLE, crc_sel=0, txe=1, no frame_done; the next frame's CRC matches a fresh golden value.
- rst_n low mid-PRESENT -> all outputs at reset values asynchronously; after release, idle until s_valid.
